// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC and keeps at most one request in
// flight to instruction memory. The fetched word is held for IF/ID until consumed.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] ins_o,
  output logic [31:0] pc_o,
  output logic        valid_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {ISSUE, WAIT, DROP, FULL} state_e;

  state_e      state_q, state_d;
  logic [31:0] fpc_q, fpc_d;
  logic [31:0] ins_q, ins_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic        misalign_q, misalign_d;
  logic        req;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ISSUE;
      fpc_q      <= RESET_PC;
      ins_q      <= '0;
      pc_q       <= '0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fpc_q      <= fpc_d;
      ins_q      <= ins_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fpc_d      = fpc_q;
    ins_d      = ins_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    misalign_d = redirect_i && (redirect_pc_i[1:0] != 2'b00);
    req        = 1'b0;
    // Redirect always retargets the fetch PC, whatever the state does next.
    if (redirect_i) fpc_d = {redirect_pc_i[31:2], 2'b00};
    case (state_q)
      ISSUE: begin
        if (!redirect_i) begin
          req     = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid_i && !redirect_i) begin
          ins_d   = imem_rdata_i;
          pc_d    = fpc_q;
          valid_d = 1'b1;
          fpc_d   = fpc_q + 32'd4;
          state_d = FULL;
        end else if (imem_rvalid_i) begin
          state_d = ISSUE;
        end else if (redirect_i) begin
          state_d = DROP;
        end
      end
      // The stale response must drain before a new request may go out.
      DROP: begin
        if (imem_rvalid_i) state_d = ISSUE;
      end
      FULL: begin
        if (redirect_i) begin
          valid_d = 1'b0;
          ins_d   = '0;
          pc_d    = '0;
          state_d = ISSUE;
        end else if (!stall_i) begin
          req     = 1'b1;
          valid_d = 1'b0;
          ins_d   = '0;
          pc_d    = '0;
          state_d = WAIT;
        end
      end
      default: state_d = ISSUE;
    endcase
  end

  // Gated by reset so no request leaks out while the flops are held clear.
  assign imem_req_o  = req && rst_ni;
  assign imem_addr_o = fpc_q;
  assign ins_o       = ins_q;
  assign pc_o        = pc_q;
  assign valid_o     = valid_q;
  assign misalign_o  = misalign_q;

endmodule
